flopoco_facc_6_6: RTL and testbench

- Streaming exact accumulator placed directly downstream of the fmul core.
- Consumes 15-bit FloPoCo words of the form {exc[1:0], sign, exp[5:0], frac[5:0]} (bias 31) and sums each frame into a wide two's-complement fixed-point register (Kulisch style), so per-term rounding never occurs.
- On the beat marked last, it normalises and rounds once to a FloPoCo word.
- Used to reduce dot-product partial products.

---
 rtl/flopoco_pkg.sv | 31 +++
 rtl/flopoco_round_pack.sv | 60 ++++++
 rtl/flopoco_facc_6_6.sv | 180 ++++++++++++++++++
 tb/tb_flopoco_facc_6_6.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flopoco_pkg.sv
// Shared definitions for the FloPoCo accumulator: format defaults, field positions,
// exception codes and the accumulator state encoding.
package flopoco_pkg;

   localparam int FP_WE    = 6;
   localparam int FP_WF    = 6;
   localparam int FP_GUARD = 9;
   localparam int FP_BIAS  = 2**(FP_WE-1) - 1;
   localparam int FP_W     = FP_WE + FP_WF + 3;

   localparam int FRAC_LSB = 0;
   localparam int EXP_LSB  = FP_WF;
   localparam int SIGN_BIT = FP_WE + FP_WF;
   localparam int EXC_LSB  = FP_WE + FP_WF + 1;

   typedef enum logic [1:0] {
      EXC_ZERO = 2'b00,
      EXC_NORM = 2'b01,
      EXC_INF  = 2'b10,
      EXC_NAN  = 2'b11
   } exc_e;

   typedef enum logic [2:0] {
      ST_ACC,
      ST_ABS,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

endpackage

// File: rtl/flopoco_round_pack.sv
// Rounds a left-normalised accumulator magnitude to nearest-even and packs the
// FloPoCo result word, applying exception and range priorities.
module flopoco_round_pack #(
   parameter int WE    = flopoco_pkg::FP_WE,
   parameter int WF    = flopoco_pkg::FP_WF,
   parameter int GUARD = flopoco_pkg::FP_GUARD,
   parameter int ACC_W = 2**WE + WF + 1 + GUARD,
   parameter int KW    = $clog2(ACC_W + 1)
) (
   input  logic [ACC_W-1:0]    mag_i,
   input  logic [KW-1:0]       k_i,
   input  logic                rsign_i,
   input  logic                pinf_i,
   input  logic                ninf_i,
   input  logic                nan_i,
   input  logic                ovf_i,
   output logic [WE+WF+2:0]    data_o
);
   import flopoco_pkg::*;

   logic [WF:0]   mant;
   logic          guard_bit;
   logic          sticky;
   logic          rnd_up;
   logic [WF+1:0] mant_r;
   logic [WF-1:0] frac_r;
   int            exp_r;

   assign mant      = mag_i[ACC_W-1 -: WF+1];
   assign guard_bit = mag_i[ACC_W-2-WF];
   assign sticky    = |mag_i[ACC_W-3-WF:0];
   assign rnd_up    = guard_bit & (sticky | mant[0]);
   assign mant_r    = {1'b0, mant} + {{(WF+1){1'b0}}, rnd_up};

   // The top bit of mag sits at position ACC_W-1-k, whose biased exponent is that minus WF.
   always_comb begin
      exp_r  = ACC_W - 1 - WF - int'(k_i);
      frac_r = mant_r[WF-1:0];
      if (mant_r[WF+1]) begin
         exp_r  = exp_r + 1;
         frac_r = '0;
      end

      data_o = {EXC_NORM, rsign_i, exp_r[WE-1:0], frac_r};
      if (nan_i || (pinf_i && ninf_i)) begin
         data_o = {EXC_NAN, 1'b0, {(WE+WF){1'b0}}};
      end else if (pinf_i || ninf_i) begin
         data_o = {EXC_INF, ninf_i, {(WE+WF){1'b0}}};
      end else if (ovf_i) begin
         data_o = {EXC_INF, rsign_i, {(WE+WF){1'b0}}};
      end else if (mag_i == '0) begin
         data_o = '0;
      end else if (exp_r < 0) begin
         data_o = {EXC_ZERO, rsign_i, {(WE+WF){1'b0}}};
      end else if (exp_r > 2**WE - 1) begin
         data_o = {EXC_INF, rsign_i, {(WE+WF){1'b0}}};
      end
   end

endmodule

// File: rtl/flopoco_facc_6_6.sv
// Exact (Kulisch) accumulator for FloPoCo words: sums a frame into a wide
// fixed-point register and rounds once when the last beat has been absorbed.
module flopoco_facc_6_6 #(
   parameter int WE    = flopoco_pkg::FP_WE,
   parameter int WF    = flopoco_pkg::FP_WF,
   parameter int GUARD = flopoco_pkg::FP_GUARD
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WE+WF+2:0]    in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WE+WF+2:0]    out_data,
   output logic                out_ovf
);
   import flopoco_pkg::*;

   localparam int W     = WE + WF + 3;
   localparam int ACC_W = 2**WE + WF + 1 + GUARD;
   localparam int KW    = $clog2(ACC_W + 1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] mag_q, mag_d;
   logic [KW-1:0]    k_q, k_d;
   logic             rsign_q, rsign_d;
   logic             pinf_q, pinf_d;
   logic             ninf_q, ninf_d;
   logic             nan_q, nan_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             out_ovf_q, out_ovf_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [W-1:0]     rounded;

   exc_e             in_exc;
   logic             in_sign;
   logic [WE-1:0]    in_exp;
   logic [WF-1:0]    in_frac;
   logic [ACC_W-1:0] term, addend, sum;
   logic             add_ovf;

   assign in_exc  = exc_e'(in_data[W-1 -: 2]);
   assign in_sign = in_data[WE+WF];
   assign in_exp  = in_data[WF +: WE];
   assign in_frac = in_data[WF-1:0];

   // Hidden-one mantissa shifted to its fixed-point weight; LSB of acc is 2^-(BIAS+WF).
   always_comb begin
      term       = '0;
      term[WF:0] = {1'b1, in_frac};
      term       = term << in_exp;
      addend     = in_sign ? -term : term;
      sum        = acc_q + addend;
      add_ovf    = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
   end

   flopoco_round_pack #(
      .WE    (WE),
      .WF    (WF),
      .GUARD (GUARD),
      .ACC_W (ACC_W),
      .KW    (KW)
   ) u_round_pack (
      .mag_i   (mag_q),
      .k_i     (k_q),
      .rsign_i (rsign_q),
      .pinf_i  (pinf_q),
      .ninf_i  (ninf_q),
      .nan_i   (nan_q),
      .ovf_i   (ovf_q),
      .data_o  (rounded)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mag_d       = mag_q;
      k_d         = k_q;
      rsign_d     = rsign_q;
      pinf_d      = pinf_q;
      ninf_d      = ninf_q;
      nan_d       = nan_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_ovf_d   = out_ovf_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_ACC: begin
            if (in_valid) begin
               case (in_exc)
                  EXC_NORM: begin
                     acc_d = sum;
                     if (add_ovf) ovf_d = 1'b1;
                  end
                  EXC_INF: begin
                     if (in_sign) ninf_d = 1'b1;
                     else         pinf_d = 1'b1;
                  end
                  EXC_NAN:  nan_d = 1'b1;
                  default:  ;
               endcase
               if (in_last) state_d = ST_ABS;
            end
         end
         ST_ABS: begin
            mag_d   = acc_q[ACC_W-1] ? -acc_q : acc_q;
            rsign_d = acc_q[ACC_W-1];
            k_d     = '0;
            state_d = ST_NORM;
         end
         ST_NORM: begin
            if (mag_q == '0 || mag_q[ACC_W-1]) begin
               state_d = ST_ROUND;
            end else begin
               mag_d = mag_q << 1;
               k_d   = k_q + KW'(1);
            end
         end
         ST_ROUND: begin
            out_data_d  = rounded;
            out_valid_d = 1'b1;
            out_ovf_d   = ovf_q;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               pinf_d      = 1'b0;
               ninf_d      = 1'b0;
               nan_d       = 1'b0;
               ovf_d       = 1'b0;
               state_d     = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         mag_q       <= '0;
         k_q         <= '0;
         rsign_q     <= 1'b0;
         pinf_q      <= 1'b0;
         ninf_q      <= 1'b0;
         nan_q       <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mag_q       <= mag_d;
         k_q         <= k_d;
         rsign_q     <= rsign_d;
         pinf_q      <= pinf_d;
         ninf_q      <= ninf_d;
         nan_q       <= nan_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_ovf_q   <= out_ovf_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_flopoco_facc_6_6.sv
// Bench for the exact FloPoCo accumulator: directed frames from worked examples plus
// random frames checked against an arbitrary-precision integer model.
module tb_flopoco_facc_6_6;
   import flopoco_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_data;
   logic        out_ovf;

   int vectors = 0;
   int miscompares = 0;

   logic [14:0] frame_words [600];
   int          frame_len;

   always #5 clk = ~clk;

   flopoco_facc_6_6 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: exact integer sum in units of 2^-37, wrapped to 80 bits, then rounded
   // by arithmetic on the leading-bit position.
   function automatic void model_frame(output logic [14:0] res, output logic ovf_m, output int lat);
      logic signed [127:0] acc, exact, term, maxv, minv;
      logic [127:0] mag, q, rem, half;
      logic [14:0] w;
      bit pinf, ninf, nan, rsign;
      int p, sh, e;
      acc = '0; ovf_m = 1'b0; pinf = 0; ninf = 0; nan = 0;
      maxv = 128'sd1; maxv = (maxv <<< 79) - 128'sd1; minv = -maxv - 128'sd1;
      for (int i = 0; i < frame_len; i++) begin
         w = frame_words[i];
         case (w[EXC_LSB +: 2])
            2'b01: begin
               term = 128'(64 + int'(w[FRAC_LSB +: 6]));
               term = term << w[EXP_LSB +: 6];
               exact = w[SIGN_BIT] ? acc - term : acc + term;
               if (exact > maxv || exact < minv) ovf_m = 1'b1;
               acc = {{48{exact[79]}}, exact[79:0]};
            end
            2'b10: if (w[SIGN_BIT]) ninf = 1; else pinf = 1;
            2'b11: nan = 1;
            default: ;
         endcase
      end
      rsign = (acc < 0);
      mag = rsign ? -acc : acc;
      p = -1;
      for (int b = 0; b < 128; b++) if (mag[b]) p = b;
      lat = (p < 0) ? 3 : (79 - p) + 3;
      e = p - 6;
      q = '0;
      if (p >= 6) begin
         sh = p - 6;
         q = mag >> sh;
         rem = mag - (q << sh);
         half = (sh > 0) ? (128'd1 << (sh - 1)) : 128'd0;
         if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
         if (q == 128) begin q = 64; e = e + 1; end
      end
      if (nan || (pinf && ninf))  res = 15'h6000;
      else if (pinf)               res = 15'h4000;
      else if (ninf)               res = 15'h5000;
      else if (ovf_m)              res = {2'b10, rsign, 12'h000};
      else if (p < 0)              res = 15'h0000;
      else if (e < 0)              res = {2'b00, rsign, 12'h000};
      else if (e > 63)             res = {2'b10, rsign, 12'h000};
      else                         res = {2'b01, rsign, 6'(e), q[5:0]};
   endfunction

   function automatic logic [14:0] gen_word(input bit wide);
      int r;
      logic [14:0] w;
      r = $urandom_range(0, 99);
      w = 15'($urandom);
      if (r < 4)       w[14:13] = 2'b10;
      else if (r < 6)  w[14:13] = 2'b11;
      else if (r < 12) w[14:13] = 2'b00;
      else begin
         w[14:13] = 2'b01;
         w[11:6]  = wide ? 6'($urandom_range(0, 63)) : 6'($urandom_range(25, 37));
      end
      return w;
   endfunction

   task automatic send_frame(input bit gaps, output logic [14:0] got, output logic got_ovf,
                             output int edges, output bit timeout);
      int wait_cnt;
      timeout = 0; edges = 0;
      for (int i = 0; i < frame_len; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0; in_data = 15'($urandom); in_last = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1; in_data = frame_words[i]; in_last = (i == frame_len - 1);
         wait_cnt = 0;
         while (!in_ready && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
         if (!in_ready) timeout = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      while (!out_valid && edges < 200) begin @(posedge clk); #1; edges++; end
      if (!out_valid) timeout = 1;
      got = out_data; got_ovf = out_ovf;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 15'h0000 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b vld=%b data=%h ovf=%b, want 1 0 0000 0",
                  in_ready, out_valid, out_data, out_ovf);
      end
      rst = 1'b0;
      $display("[TB] reset checked");
   endtask

   task automatic test_directed();
      logic [14:0] da [8];
      logic [14:0] db [8];
      logic [14:0] dexp [8];
      int dn [8];
      int dlat [8];
      logic [14:0] got; logic got_o; int got_l; bit tmo;
      da   = '{15'h27C0, 15'h27C0, 15'h27E0, 15'h27C0, 15'h27C1, 15'h27C0, 15'h4000, 15'h27C0};
      db   = '{15'h0000, 15'h37C0, 15'h27E0, 15'h2600, 15'h2600, 15'h4000, 15'h5000, 15'h6000};
      dn   = '{1, 2, 2, 2, 2, 2, 2, 2};
      dexp = '{15'h27C0, 15'h0000, 15'h2820, 15'h27C0, 15'h27C2, 15'h4000, 15'h6000, 15'h6000};
      dlat = '{45, 3, 44, 45, 45, 45, 3, 45};
      for (int t = 0; t < 8; t++) begin
         frame_words[0] = da[t]; frame_words[1] = db[t]; frame_len = dn[t];
         send_frame(1'b0, got, got_o, got_l, tmo);
         vectors++;
         if (tmo) begin
            miscompares++;
            $display("FAIL dir%0d_timeout: no result within bound", t);
         end else begin
            if (got !== dexp[t]) begin
               miscompares++;
               $display("FAIL dir%0d_data: got %h want %h", t, got, dexp[t]);
            end
            vectors++;
            if (got_o !== 1'b0) begin
               miscompares++;
               $display("FAIL dir%0d_ovf: got %b want 0", t, got_o);
            end
            vectors++;
            if (got_l !== dlat[t]) begin
               miscompares++;
               $display("FAIL dir%0d_latency: got %0d want %0d", t, got_l, dlat[t]);
            end
         end
         consume();
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dir%0d_release: got vld=%b rdy=%b want 0 1", t, out_valid, in_ready);
         end
      end
      $display("[TB] directed frames done");
   endtask

   task automatic test_backpressure();
      logic [14:0] got; logic got_o; int got_l; bit tmo;
      frame_words[0] = 15'h27E0; frame_len = 1;
      send_frame(1'b0, got, got_o, got_l, tmo);
      vectors++;
      if (tmo || got !== 15'h27E0) begin
         miscompares++;
         $display("FAIL bp_data: got %h want 27e0 (timeout=%0d)", got, tmo);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = (c % 2 == 0); in_data = 15'h27C0; in_last = 1'b1;
         @(posedge clk); #1;
         vectors++;
         if (out_data !== 15'h27E0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got data=%h vld=%b rdy=%b want 27e0 1 0",
                     c, out_data, out_valid, in_ready);
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      consume();
      frame_words[0] = 15'h27C0; frame_len = 1;
      send_frame(1'b0, got, got_o, got_l, tmo);
      vectors++;
      if (tmo || got !== 15'h27C0) begin
         miscompares++;
         $display("FAIL bp_next: got %h want 27c0 (timeout=%0d)", got, tmo);
      end
      consume();
      $display("[TB] backpressure done");
   endtask

   task automatic test_reset_abort();
      logic [14:0] got; logic got_o; int got_l; bit tmo;
      bit seen;
      in_valid = 1'b1; in_data = 15'h27E0; in_last = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (out_data !== 15'h0000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_frame: got data=%h rdy=%b vld=%b want 0000 1 0",
                  out_data, in_ready, out_valid);
      end
      frame_words[0] = 15'h27C0; frame_len = 1;
      send_frame(1'b0, got, got_o, got_l, tmo);
      vectors++;
      if (tmo || got !== 15'h27C0 || got_l !== 45) begin
         miscompares++;
         $display("FAIL rst_fresh_frame: got %h lat %0d want 27c0 lat 45", got, got_l);
      end
      consume();

      in_valid = 1'b1; in_data = 15'h27C0; in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL norm_busy: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL rst_mid_norm: got out_valid=1 after abort want 0");
      end
      frame_words[0] = 15'h2820; frame_len = 1;
      send_frame(1'b0, got, got_o, got_l, tmo);
      vectors++;
      if (tmo || got !== 15'h2820 || got_l !== 44) begin
         miscompares++;
         $display("FAIL rst_after_norm: got %h lat %0d want 2820 lat 44", got, got_l);
      end
      consume();
      $display("[TB] reset abort done");
   endtask

   task automatic test_overflow();
      logic [14:0] got, exp_d; logic got_o, exp_o; int got_l, exp_l; bit tmo;
      frame_len = 520;
      for (int i = 0; i < frame_len; i++) frame_words[i] = 15'h2FFF;
      model_frame(exp_d, exp_o, exp_l);
      send_frame(1'b0, got, got_o, got_l, tmo);
      vectors++;
      if (tmo || got !== exp_d || got_l !== exp_l) begin
         miscompares++;
         $display("FAIL ovf_data: got %h lat %0d want %h lat %0d", got, got_l, exp_d, exp_l);
      end
      vectors++;
      if (got_o !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_flag: got %b want 1", got_o);
      end
      consume();
      $display("[TB] overflow done");
   endtask

   task automatic test_random();
      logic [14:0] got, exp_d; logic got_o, exp_o; int got_l, exp_l; bit tmo;
      for (int f = 0; f < 40; f++) begin
         frame_len = $urandom_range(1, 6);
         for (int i = 0; i < frame_len; i++) frame_words[i] = gen_word(f % 2 == 1);
         model_frame(exp_d, exp_o, exp_l);
         send_frame(1'b1, got, got_o, got_l, tmo);
         vectors++;
         if (tmo) begin
            miscompares++;
            $display("FAIL rand%0d_timeout: no result within bound", f);
         end else begin
            if (got !== exp_d) begin
               miscompares++;
               $display("FAIL rand%0d_data: got %h want %h", f, got, exp_d);
            end
            vectors++;
            if (got_o !== exp_o) begin
               miscompares++;
               $display("FAIL rand%0d_ovf: got %b want %b", f, got_o, exp_o);
            end
            vectors++;
            if (got_l !== exp_l) begin
               miscompares++;
               $display("FAIL rand%0d_latency: got %0d want %0d", f, got_l, exp_l);
            end
         end
         consume();
      end
      $display("[TB] random frames done");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_overflow();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
